// File: rtl/ray_gen_if.sv
// FIFO write bus between the ray generator and the p_hit input FIFOs.
// Lanes: [0] origin_1, [1] origin_2, [2] dir_1, [3] dir_2.
interface ray_gen_if;
  logic [3:0]       in_full;
  logic [3:0]       in_wr_en;
  logic [2:0][31:0] origin_1;
  logic [2:0][31:0] origin_2;
  logic [2:0][31:0] dir_1;
  logic [2:0][31:0] dir_2;

  modport master (
    input  in_full,
    output in_wr_en,
    output origin_1,
    output origin_2,
    output dir_1,
    output dir_2
  );

  modport slave (
    output in_full,
    input  in_wr_en,
    input  origin_1,
    input  origin_2,
    input  dir_1,
    input  dir_2
  );
endinterface

// File: rtl/ray_gen.sv
// Pinhole-camera primary-ray generator: one Q16.16 ray per pixel in raster order,
// written to four lock-stepped FIFO lanes.
module ray_gen #(
  parameter int unsigned Q_BITS   = 16,
  parameter int unsigned IMG_W    = 64,
  parameter int unsigned IMG_H    = 48,
  parameter logic [31:0] PIX_STEP = 32'h0000_0400
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2:0][31:0]           cam_origin,
  input  logic [31:0]                focal,
  ray_gen_if.master                  fifo,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(IMG_W)-1:0]   pix_x,
  output logic [$clog2(IMG_H)-1:0]   pix_y
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  localparam logic [31:0] HalfW = 32'(IMG_W / 2);
  localparam logic [31:0] HalfH = 32'(IMG_H / 2);
  localparam logic [31:0] DirX0 = 32'd0 - (HalfW * PIX_STEP);
  localparam logic [31:0] DirY0 = HalfH * PIX_STEP;

  if (Q_BITS == 0 || Q_BITS > 31 || IMG_W < 2 || IMG_H < 2 || IMG_W % 2 != 0 ||
      IMG_H % 2 != 0) begin : g_bad_params
    $error("ray_gen: unsupported parameter set");
  end

  typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

  state_e state_q, state_d;

  logic [2:0][31:0] origin_q;
  logic [31:0]      focal_q;
  logic [31:0]      dir_x_q;
  logic [31:0]      dir_y_q;
  logic [XW-1:0]    pix_x_q;
  logic [YW-1:0]    pix_y_q;

  logic accept;
  logic last_x;
  logic last_pix;

  // All four lanes advance together; any full lane stalls the whole ray.
  assign accept   = (state_q == StEmit) && (fifo.in_full == 4'b0000);
  assign last_x   = (pix_x_q == XW'(IMG_W - 1));
  assign last_pix = last_x && (pix_y_q == YW'(IMG_H - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StEmit;
      StEmit:  if (accept && last_pix) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo.in_wr_en = {4{accept}};
    busy          = (state_q == StEmit);
    done          = (state_q == StDone);
    fifo.origin_1 = origin_q;
    fifo.origin_2 = origin_q;
    fifo.dir_1    = {focal_q, dir_y_q, dir_x_q};
    fifo.dir_2    = {focal_q, dir_y_q, dir_x_q};
    pix_x         = pix_x_q;
    pix_y         = pix_y_q;
  end

  // Directions are accumulated per accepted write rather than multiplied out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      origin_q <= '0;
      focal_q  <= '0;
      dir_x_q  <= '0;
      dir_y_q  <= '0;
      pix_x_q  <= '0;
      pix_y_q  <= '0;
    end else if ((state_q == StIdle) && start) begin
      origin_q <= cam_origin;
      focal_q  <= focal;
      dir_x_q  <= DirX0;
      dir_y_q  <= DirY0;
      pix_x_q  <= '0;
      pix_y_q  <= '0;
    end else if (accept) begin
      if (last_x) begin
        pix_x_q <= '0;
        dir_x_q <= DirX0;
        pix_y_q <= pix_y_q + YW'(1);
        dir_y_q <= dir_y_q - PIX_STEP;
      end else begin
        pix_x_q <= pix_x_q + XW'(1);
        dir_x_q <= dir_x_q + PIX_STEP;
      end
    end
  end

endmodule
